// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. A PC register addresses a combinational
// instruction memory. Each returned word is pushed, with its address, into a
// small in-order fetch buffer that feeds decode through a valid/ready
// handshake.
//
// A redirect flushes the buffer and restarts fetch at a new target. A redirect
// to a target that is not word-aligned raises a sticky error. While the error
// is set, fetch stays stopped until reset, but the buffer can still drain.
//
// Parameters
//   RESET_PC       PC value loaded on reset
//   DEPTH          fetch-buffer entries (2 or 4)
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   imem_addr      byte address to the instruction memory (the PC)
//   imem_instr     instruction word for imem_addr, same cycle
//   redirect_valid taken branch/jump: flush and restart fetch
//   redirect_pc    redirect target byte address
//   out_valid      buffer head presented to decode
//   out_ready      decode accepts the head
//   out_instr      head instruction word
//   out_pc         head instruction address
//   out_pc_plus4   out_pc + 4 (mod 2^32)
//   misaligned_err sticky flag: a redirect target was not word-aligned
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misaligned_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_pc;
  logic          r_err;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];

  logic w_pop;
  logic w_fetch_en;

  assign imem_addr      = r_pc;
  assign misaligned_err = r_err;

  // No handshake can complete in a redirect cycle, because the head is about
  // to be flushed.
  assign out_valid    = (r_count != '0) & ~redirect_valid;
  assign w_pop        = out_valid & out_ready;
  assign out_instr    = r_fifo_instr[r_rd_ptr];
  assign out_pc       = r_fifo_pc[r_rd_ptr];
  assign out_pc_plus4 = r_fifo_pc[r_rd_ptr] + 32'd4;

  // A full buffer can still accept a fetch when the head leaves in the same
  // cycle. The write then lands in the slot that the head is vacating.
  assign w_fetch_en = ~r_err & ~redirect_valid & ((r_count < FULL) | w_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_err    <= 1'b0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect_valid) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_err <= 1'b1;
      end else if (!r_err) begin
        // Once the error is set, the PC stays frozen even on an aligned
        // redirect, so the halted state keeps a stable imem_addr.
        r_pc <= redirect_pc;
      end
    end else begin
      if (w_fetch_en) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_fetch_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: buffer storage has no reset. An entry is only visible when r_count
  // covers it, so clearing the count is enough to discard the contents.
  always_ff @(posedge clk) begin
    if (w_fetch_en) begin
      r_fifo_pc[r_wr_ptr]    <= r_pc;
      r_fifo_instr[r_wr_ptr] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Instance u_dut uses the default parameters (RESET_PC 0, DEPTH 2).
// Instance u_dut_w uses RESET_PC 32'hFFFF_FFF8 and DEPTH 4, for PC wrap-around.
//
// Both instruction memories return 32'h1000_0000 + word index. Each scenario
// queues the instruction stream it expects. A negedge monitor pops the queue
// on every completed handshake and compares the three head fields.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        misaligned_err;

  // Wrap-around instance
  logic        w_rst_n = 1'b0;
  logic [31:0] w_imem_addr, w_imem_instr;
  logic        w_out_valid, w_out_ready = 1'b0;
  logic [31:0] w_out_instr, w_out_pc, w_out_pc_plus4;
  logic        w_misaligned_err;

  assign imem_instr   = 32'h1000_0000 + (imem_addr >> 2);
  assign w_imem_instr = 32'h1000_0000 + (w_imem_addr >> 2);

  fetch_unit u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4),
    .misaligned_err(misaligned_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_w (
    .clk           (clk),
    .rst_n         (w_rst_n),
    .imem_addr     (w_imem_addr),
    .imem_instr    (w_imem_instr),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0),
    .out_valid     (w_out_valid),
    .out_ready     (w_out_ready),
    .out_instr     (w_out_instr),
    .out_pc        (w_out_pc),
    .out_pc_plus4  (w_out_pc_plus4),
    .misaligned_err(w_misaligned_err)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_a[$];
  exp_t q_w[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'h1000_0000 + (pc >> 2);
    e.pc4   = pc + 32'd4;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a handshake seen at the negedge completes at the next
  // rising edge, because inputs only change just after a rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      check("a_sb_nonempty", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        exp_t e;
        e = q_a.pop_front();
        check("a_out_pc", out_pc, e.pc);
        check("a_out_instr", out_instr, e.instr);
        check("a_out_pc_plus4", out_pc_plus4, e.pc4);
      end
    end
  end

  always @(negedge clk) begin
    if (w_out_valid && w_out_ready) begin
      check("w_sb_nonempty", 32'(q_w.size() != 0), 32'd1);
      if (q_w.size() != 0) begin
        exp_t e;
        e = q_w.pop_front();
        check("w_out_pc", w_out_pc, e.pc);
        check("w_out_instr", w_out_instr, e.instr);
        check("w_out_pc_plus4", w_out_pc_plus4, e.pc4);
      end
    end
  end

  // Hold reset for two edges and release it just after a rising edge, so the
  // first fetch happens at the following rising edge.
  task automatic apply_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_misaligned", 32'(misaligned_err), 32'd0);
    tick();
    tick();
    q_a.delete();
    rst_n = 1'b1;
    check("rel_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- PC wrap-around on the RESET_PC=FFFFFFF8 instance
    tick();
    check("w_rst_imem_addr", w_imem_addr, 32'hFFFF_FFF8);
    check("w_rst_out_valid", 32'(w_out_valid), 32'd0);
    w_rst_n = 1'b1;
    q_w.push_back(mk_exp(32'hFFFF_FFF8));
    q_w.push_back(mk_exp(32'hFFFF_FFFC));
    q_w.push_back(mk_exp(32'h0000_0000));
    w_out_ready = 1'b1;
    repeat (4) tick();
    w_out_ready = 1'b0;
    check("w_drained", 32'(q_w.size()), 32'd0);

    // ---- Streaming after reset: one instruction per cycle
    apply_reset();
    for (int i = 0; i < 8; i++) q_a.push_back(mk_exp(32'(4 * i)));
    out_ready = 1'b1;
    tick();
    check("s1_first_valid", 32'(out_valid), 32'd1);
    check("s1_first_pc", out_pc, 32'h0);
    repeat (8) tick();
    out_ready = 1'b0;
    check("s1_drained", 32'(q_a.size()), 32'd0);

    // ---- Backpressure: fill to DEPTH, hold PC, then drain in order
    apply_reset();
    for (int i = 0; i < 6; i++) q_a.push_back(mk_exp(32'(4 * i)));
    repeat (3) tick();
    check("s2_full_addr", imem_addr, 32'h8);
    check("s2_full_pc", out_pc, 32'h0);
    check("s2_full_valid", 32'(out_valid), 32'd1);
    repeat (2) tick();
    check("s2_hold_addr", imem_addr, 32'h8);
    check("s2_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    check("s2_drained", 32'(q_a.size()), 32'd0);

    // ---- Aligned redirect while a head is being presented
    apply_reset();
    q_a.push_back(mk_exp(32'h0));
    out_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("s3_redir_valid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("s3_redir_addr", imem_addr, 32'h40);
    for (int i = 0; i < 3; i++) q_a.push_back(mk_exp(32'h40 + 32'(4 * i)));
    repeat (4) tick();
    out_ready = 1'b0;
    check("s3_drained", 32'(q_a.size()), 32'd0);

    // ---- Misaligned redirect: sticky error, halted fetch, reset recovers
    apply_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    #1;
    check("s4_redir_valid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    check("s4_err_set", 32'(misaligned_err), 32'd1);
    check("s4_addr_held", imem_addr, 32'h8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s4_halt_valid", 32'(out_valid), 32'd0);
      check("s4_halt_addr", imem_addr, 32'h8);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("s4_err_sticky", 32'(misaligned_err), 32'd1);
    check("s4_still_halted", 32'(out_valid), 32'd0);
    apply_reset();
    q_a.push_back(mk_exp(32'h0));
    q_a.push_back(mk_exp(32'h4));
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("s4_restart_drained", 32'(q_a.size()), 32'd0);

    // ---- Asynchronous reset with a non-empty buffer
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("s5_buffered_valid", 32'(out_valid), 32'd1);
    check("s5_buffered_pc", out_pc, 32'h100);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_async_valid", 32'(out_valid), 32'd0);
    check("s5_async_addr", imem_addr, 32'h0);
    apply_reset();
    q_a.push_back(mk_exp(32'h0));
    q_a.push_back(mk_exp(32'h4));
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("s5_drained", 32'(q_a.size()), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
